seq_ctrl: RTL

Sequence controller for the memory game; sits directly downstream of the modulo-reduction stage. It requests a fresh reduced random index each round and appends it to an internal sequence memory. It plays the whole sequence back on one-hot LEDs, then checks the player's button presses against it. It reports level, win and lose to the display logic.

---
 rtl/seq_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seq_ctrl.sv
// Memory-game sequence controller: grows a random sequence, plays it on one-hot LEDs, checks the player's presses.
// Latency: req_en one cycle after start; round = 1 + SETTLE + 1 + level*(SHOW_CYC+GAP_CYC) cycles from REQ to INPUT.
// Backpressure: none; start outside IDLE/WIN/LOSE and btn_valid outside INPUT are dropped, never queued.
//
// Ports:
//   clk, rst       clock; synchronous active-low reset
//   start          pulse, begins/restarts a game (honoured only in IDLE, WIN, LOSE)
//   index          reduced random value from the modulo stage, sampled at the end of SETTLE
//   req_en         one-cycle pulse asking the modulo stage for a new random value
//   btn_valid/code player press, code qualified by valid
//   led            one-hot playback display
//   level          current sequence length
//   busy/awaiting/win/lose  status decoded from the registered state
module seq_ctrl #(
    parameter int MAX_LEN  = 16,
    parameter int SETTLE   = 6,
    parameter int SHOW_CYC = 25000000,
    parameter int GAP_CYC  = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] index,
    output logic       req_en,
    input  logic       btn_valid,
    input  logic [2:0] btn_code,
    output logic [7:0] led,
    output logic [4:0] level,
    output logic       busy,
    output logic       awaiting,
    output logic       win,
    output logic       lose
);
    localparam int PW = $clog2(MAX_LEN);
    localparam logic [PW-1:0] PTR_ONE     = PW'(1);
    localparam logic [31:0]   SETTLE_LAST = 32'(SETTLE - 1);
    localparam logic [31:0]   SHOW_LAST   = 32'(SHOW_CYC - 1);
    localparam logic [31:0]   GAP_LAST    = 32'(GAP_CYC - 1);
    localparam logic [4:0]    LEN_MAX     = 5'(MAX_LEN);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_SETTLE,
        ST_STORE,
        ST_SHOW_ON,
        ST_SHOW_OFF,
        ST_INPUT,
        ST_WIN,
        ST_LOSE
    } state_t;

    state_t        state;
    logic [31:0]   cnt;
    logic [PW-1:0] ptr;
    logic [2:0]    mem [MAX_LEN];

    // Sequence storage is deliberately not reset: only entries below level are read.
    always_ff @(posedge clk) begin
        if (rst && state == ST_SETTLE && cnt == SETTLE_LAST) begin
            mem[level[PW-1:0]] <= index;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            req_en <= 1'b0;
            led    <= 8'd0;
            level  <= 5'd0;
            ptr    <= '0;
            cnt    <= 32'd0;
        end else begin
            req_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_REQ;
                        req_en <= 1'b1;
                    end
                end
                ST_REQ: begin
                    state <= ST_SETTLE;
                    cnt   <= 32'd0;
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= ST_STORE;
                        cnt   <= 32'd0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_STORE: begin
                    // WIN is taken at level == MAX_LEN, so this increment never wraps.
                    level <= level + 5'd1;
                    ptr   <= '0;
                    cnt   <= 32'd0;
                    led   <= 8'd1 << mem[0];
                    state <= ST_SHOW_ON;
                end
                ST_SHOW_ON: begin
                    if (cnt == SHOW_LAST) begin
                        cnt   <= 32'd0;
                        led   <= 8'd0;
                        state <= ST_SHOW_OFF;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_SHOW_OFF: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= 32'd0;
                        if (5'(ptr) + 5'd1 == level) begin
                            ptr   <= '0;
                            state <= ST_INPUT;
                        end else begin
                            ptr   <= ptr + PTR_ONE;
                            led   <= 8'd1 << mem[ptr + PTR_ONE];
                            state <= ST_SHOW_ON;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_INPUT: begin
                    // start has no effect here even when it coincides with a press.
                    if (btn_valid) begin
                        if (btn_code != mem[ptr]) begin
                            state <= ST_LOSE;
                        end else if (5'(ptr) == level - 5'd1) begin
                            if (level == LEN_MAX) begin
                                state <= ST_WIN;
                            end else begin
                                state  <= ST_REQ;
                                req_en <= 1'b1;
                            end
                        end else begin
                            ptr <= ptr + PTR_ONE;
                        end
                    end
                end
                ST_WIN, ST_LOSE: begin
                    if (start) begin
                        level  <= 5'd0;
                        ptr    <= '0;
                        state  <= ST_REQ;
                        req_en <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state == ST_REQ) || (state == ST_SETTLE) || (state == ST_STORE) ||
                      (state == ST_SHOW_ON) || (state == ST_SHOW_OFF);
    assign awaiting = (state == ST_INPUT);
    assign win      = (state == ST_WIN);
    assign lose     = (state == ST_LOSE);

endmodule
